lib_arb_rr_pkt: RTL and testbench

LIB_ARB_RR_PKT -- requirements
Module: lib_arb_rr_pkt

---
 rtl/lib_arb_rr_pkt.sv | 154 +++++++++++++++
 tb/tb_lib_arb_rr_pkt.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lib_arb_rr_pkt.sv
// Packet-aware round-robin arbiter: a grant is held from the first beat to the beat with last set.
// Define LIB_ARB_RR_PKT_OUT_REG_EN to add a one-entry output register; the default build is combinational.
module lib_arb_rr_pkt #(
    parameter int PORTS_NUMBER = 4,
    parameter int WIDTH        = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [PORTS_NUMBER-1:0] vld_i,
    input  logic [WIDTH-1:0]        data_i [PORTS_NUMBER-1:0],
    input  logic [PORTS_NUMBER-1:0] last_i,
    output logic [PORTS_NUMBER-1:0] rdy_o,
    output logic                    vld_o,
    output logic [WIDTH-1:0]        data_o,
    output logic                    last_o,
    input  logic                    rdy_i,
    output logic [PORTS_NUMBER-1:0] grant_o,
    output logic                    busy_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [PORTS_NUMBER-1:0] base_q, base_d;
    logic [PORTS_NUMBER-1:0] lock_grant_q, lock_grant_d;

    logic [PORTS_NUMBER-1:0] mask_hi;
    logic [PORTS_NUMBER-1:0] req_hi;
    logic [PORTS_NUMBER-1:0] req_pick;
    logic [PORTS_NUMBER-1:0] rr_grant;
    logic [PORTS_NUMBER-1:0] grant;

    logic                    sel_vld;
    logic [WIDTH-1:0]        sel_data;
    logic                    sel_last;
    logic                    int_rdy;
    logic                    accept;

    function automatic logic [PORTS_NUMBER-1:0] rotl1(input logic [PORTS_NUMBER-1:0] v);
        return {v[PORTS_NUMBER-2:0], v[PORTS_NUMBER-1]};
    endfunction

    // Lowest requester at or above base; if none, lowest requester overall (the wrap).
    always_comb begin
        mask_hi  = ~(base_q - {{(PORTS_NUMBER-1){1'b0}}, 1'b1});
        req_hi   = vld_i & mask_hi;
        req_pick = (req_hi != '0) ? req_hi : vld_i;
        rr_grant = req_pick & (~req_pick + {{(PORTS_NUMBER-1){1'b0}}, 1'b1});
    end

    always_comb begin
        grant = rr_grant;
        if (state_q == ST_LOCK) begin
            grant = lock_grant_q;
        end
    end

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < PORTS_NUMBER; i++) begin
            if (grant[i]) begin
                sel_data = sel_data | data_i[i];
                sel_last = sel_last | last_i[i];
            end
        end
        sel_vld = |(vld_i & grant);
    end

    assign accept = sel_vld & int_rdy;

    // Ready goes only to the granted port while it presents a beat, so a paused lock owner sees 0.
    assign rdy_o   = grant & vld_i & {PORTS_NUMBER{int_rdy}};
    assign grant_o = grant;
    assign busy_o  = (state_q == ST_LOCK);

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        lock_grant_d = lock_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (sel_last) begin
                        base_d = rotl1(grant);
                    end else begin
                        state_d      = ST_LOCK;
                        lock_grant_d = grant;
                    end
                end
            end
            ST_LOCK: begin
                if (accept && sel_last) begin
                    state_d      = ST_IDLE;
                    base_d       = rotl1(lock_grant_q);
                    lock_grant_d = '0;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                base_d       = {{(PORTS_NUMBER-1){1'b0}}, 1'b1};
                lock_grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            base_q       <= {{(PORTS_NUMBER-1){1'b0}}, 1'b1};
            lock_grant_q <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            lock_grant_q <= lock_grant_d;
        end
    end

`ifdef LIB_ARB_RR_PKT_OUT_REG_EN
    logic             out_vld_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_last_q;

    // The slot can accept a new beat when empty or when its current beat leaves this cycle.
    assign int_rdy = ~out_vld_q | rdy_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
        end else if (accept) begin
            out_vld_q  <= 1'b1;
            out_data_q <= sel_data;
            out_last_q <= sel_last;
        end else if (rdy_i) begin
            out_vld_q  <= 1'b0;
        end
    end

    assign vld_o  = out_vld_q;
    assign data_o = out_data_q;
    assign last_o = out_last_q;
`else
    assign int_rdy = rdy_i;
    assign vld_o   = sel_vld;
    assign data_o  = sel_data;
    assign last_o  = sel_last;
`endif

endmodule

// File: tb/tb_lib_arb_rr_pkt.sv
// Directed bench for lib_arb_rr_pkt (4 ports, 8-bit data); beats leaving the arbiter are logged
// by a monitor so packet contents are checked independently of output-stage latency.
module tb_lib_arb_rr_pkt;

    logic       clk;
    logic       rstn;
    logic [3:0] vld_i;
    logic [7:0] data_i [3:0];
    logic [3:0] last_i;
    logic [3:0] rdy_o;
    logic       vld_o;
    logic [7:0] data_o;
    logic       last_o;
    logic       rdy_i;
    logic [3:0] grant_o;
    logic       busy_o;

    int total = 0;
    int bad   = 0;

    logic [8:0] mon_q [$];

    lib_arb_rr_pkt #(.PORTS_NUMBER(4), .WIDTH(8)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .vld_i   (vld_i),
        .data_i  (data_i),
        .last_i  (last_i),
        .rdy_o   (rdy_o),
        .vld_o   (vld_o),
        .data_o  (data_o),
        .last_o  (last_o),
        .rdy_i   (rdy_i),
        .grant_o (grant_o),
        .busy_o  (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rstn && vld_o && rdy_i) mon_q.push_back({last_o, data_o});
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        vld_i  = 4'b0000;
        last_i = 4'b0000;
        rdy_i  = 1'b1;
        repeat (3) tick();
    endtask

    task automatic do_reset();
        rstn   = 1'b0;
        vld_i  = 4'b0000;
        last_i = 4'b0000;
        rdy_i  = 1'b1;
        for (int i = 0; i < 4; i++) data_i[i] = 8'h00;
        #3;
        tick();
        rstn = 1'b1;
        mon_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        total++; if (vld_o !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b exp=0", vld_o); end
        total++; if (grant_o !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b exp=0000", grant_o); end
        total++; if (rdy_o !== 4'b0000) begin bad++; $display("FAIL reset_rdy got=%b exp=0000", rdy_o); end
        total++; if (data_o !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data_o); end
        total++; if (last_o !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", last_o); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5];
        int         exp_p [5];
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        exp_p[0] = 0; exp_p[1] = 1; exp_p[2] = 2; exp_p[3] = 3; exp_p[4] = 0;
        do_reset();
        vld_i  = 4'b1111;
        last_i = 4'b1111;
        for (int i = 0; i < 4; i++) data_i[i] = 8'h50 + 8'(i);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++; if (grant_o !== exp_g[c]) begin bad++; $display("FAIL rr_grant[%0d] got=%b exp=%b", c, grant_o, exp_g[c]); end
            total++; if (rdy_o !== exp_g[c]) begin bad++; $display("FAIL rr_rdy[%0d] got=%b exp=%b", c, rdy_o, exp_g[c]); end
            tick();
        end
        drain();
        total++; if (mon_q.size() !== 5) begin bad++; $display("FAIL rr_beats got=%0d exp=5", mon_q.size()); end
        for (int c = 0; c < 5 && c < mon_q.size(); c++) begin
            total++;
            if (mon_q[c] !== {1'b1, 8'h50 + 8'(exp_p[c])}) begin
                bad++; $display("FAIL rr_beat[%0d] got=%h exp=%h", c, mon_q[c], {1'b1, 8'h50 + 8'(exp_p[c])});
            end
        end
    endtask

    task automatic test_packet_lock();
        logic [8:0] exp_b [4];
        exp_b[0] = {1'b0, 8'hA1}; exp_b[1] = {1'b0, 8'hA2}; exp_b[2] = {1'b1, 8'hA3}; exp_b[3] = {1'b1, 8'hB0};
        do_reset();
        vld_i = 4'b0110; last_i = 4'b0100; data_i[1] = 8'hA1; data_i[2] = 8'hB0;
        @(negedge clk);
        total++; if (grant_o !== 4'b0010) begin bad++; $display("FAIL lock_grant_b1 got=%b exp=0010", grant_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL lock_busy_b1 got=%b exp=0", busy_o); end
        tick();
        data_i[1] = 8'hA2;
        @(negedge clk);
        total++; if (grant_o !== 4'b0010) begin bad++; $display("FAIL lock_grant_b2 got=%b exp=0010", grant_o); end
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL lock_busy_b2 got=%b exp=1", busy_o); end
        tick();
        data_i[1] = 8'hA3; last_i = 4'b0110;
        @(negedge clk);
        total++; if (grant_o !== 4'b0010) begin bad++; $display("FAIL lock_grant_b3 got=%b exp=0010", grant_o); end
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL lock_busy_b3 got=%b exp=1", busy_o); end
        tick();
        vld_i = 4'b0100;
        @(negedge clk);
        total++; if (grant_o !== 4'b0100) begin bad++; $display("FAIL lock_next_grant got=%b exp=0100", grant_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL lock_next_busy got=%b exp=0", busy_o); end
        tick();
        drain();
        total++; if (mon_q.size() !== 4) begin bad++; $display("FAIL lock_beats got=%0d exp=4", mon_q.size()); end
        for (int c = 0; c < 4 && c < mon_q.size(); c++) begin
            total++; if (mon_q[c] !== exp_b[c]) begin bad++; $display("FAIL lock_beat[%0d] got=%h exp=%h", c, mon_q[c], exp_b[c]); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        vld_i = 4'b1000; last_i = 4'b1111; data_i[3] = 8'h33; data_i[0] = 8'h30;
        @(negedge clk);
        total++; if (grant_o !== 4'b1000) begin bad++; $display("FAIL wrap_first got=%b exp=1000", grant_o); end
        tick();
        vld_i = 4'b0000;
        @(negedge clk);
        total++; if (grant_o !== 4'b0000) begin bad++; $display("FAIL wrap_none got=%b exp=0000", grant_o); end
        total++; if (vld_o !== 1'b0 && rdy_i === 1'b1 && 0) begin bad++; end
        tick();
        vld_i = 4'b1001;
        @(negedge clk);
        total++; if (grant_o !== 4'b0001) begin bad++; $display("FAIL wrap_port0 got=%b exp=0001", grant_o); end
        tick();
        @(negedge clk);
        total++; if (grant_o !== 4'b1000) begin bad++; $display("FAIL wrap_port3 got=%b exp=1000", grant_o); end
        tick();
        drain();
        total++; if (mon_q.size() !== 3) begin bad++; $display("FAIL wrap_beats got=%0d exp=3", mon_q.size()); end
        if (mon_q.size() == 3) begin
            total++; if (mon_q[1] !== {1'b1, 8'h30}) begin bad++; $display("FAIL wrap_beat1 got=%h exp=130", mon_q[1]); end
        end
    endtask

    task automatic test_vld_drop();
        logic [8:0] exp_b [3];
        exp_b[0] = {1'b0, 8'h10}; exp_b[1] = {1'b1, 8'h11}; exp_b[2] = {1'b1, 8'h20};
        do_reset();
        vld_i = 4'b0001; last_i = 4'b0000; data_i[0] = 8'h10;
        tick();
        vld_i = 4'b0010; last_i = 4'b0010; data_i[1] = 8'h20;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++; if (grant_o !== 4'b0001) begin bad++; $display("FAIL drop_grant[%0d] got=%b exp=0001", c, grant_o); end
            total++; if (rdy_o !== 4'b0000) begin bad++; $display("FAIL drop_rdy[%0d] got=%b exp=0000", c, rdy_o); end
            total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL drop_busy[%0d] got=%b exp=1", c, busy_o); end
`ifndef LIB_ARB_RR_PKT_OUT_REG_EN
            total++; if (vld_o !== 1'b0) begin bad++; $display("FAIL drop_vld[%0d] got=%b exp=0", c, vld_o); end
`endif
            tick();
        end
        vld_i = 4'b0011; last_i = 4'b0011; data_i[0] = 8'h11;
        @(negedge clk);
        total++; if (rdy_o !== 4'b0001) begin bad++; $display("FAIL drop_resume_rdy got=%b exp=0001", rdy_o); end
        tick();
        @(negedge clk);
        total++; if (grant_o !== 4'b0010) begin bad++; $display("FAIL drop_after_grant got=%b exp=0010", grant_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL drop_after_busy got=%b exp=0", busy_o); end
        tick();
        drain();
        total++; if (mon_q.size() !== 3) begin bad++; $display("FAIL drop_beats got=%0d exp=3", mon_q.size()); end
        for (int c = 0; c < 3 && c < mon_q.size(); c++) begin
            total++; if (mon_q[c] !== exp_b[c]) begin bad++; $display("FAIL drop_beat[%0d] got=%h exp=%h", c, mon_q[c], exp_b[c]); end
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp_hold;
        logic [8:0] exp_b [3];
`ifdef LIB_ARB_RR_PKT_OUT_REG_EN
        exp_hold = 8'hC1;
`else
        exp_hold = 8'hC2;
`endif
        exp_b[0] = {1'b0, 8'hC1}; exp_b[1] = {1'b0, 8'hC2}; exp_b[2] = {1'b1, 8'hC3};
        do_reset();
        vld_i = 4'b1000; last_i = 4'b0000; data_i[3] = 8'hC1;
        tick();
        data_i[3] = 8'hC2; rdy_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (rdy_o !== 4'b0000) begin bad++; $display("FAIL stall_rdy[%0d] got=%b exp=0000", c, rdy_o); end
            total++; if (data_o !== exp_hold) begin bad++; $display("FAIL stall_data[%0d] got=%h exp=%h", c, data_o, exp_hold); end
            total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL stall_busy[%0d] got=%b exp=1", c, busy_o); end
            tick();
        end
        rdy_i = 1'b1;
        @(negedge clk);
        total++; if (rdy_o !== 4'b1000) begin bad++; $display("FAIL stall_release_rdy got=%b exp=1000", rdy_o); end
        tick();
        data_i[3] = 8'hC3; last_i = 4'b1000;
        tick();
        drain();
        total++; if (mon_q.size() !== 3) begin bad++; $display("FAIL stall_beats got=%0d exp=3", mon_q.size()); end
        for (int c = 0; c < 3 && c < mon_q.size(); c++) begin
            total++; if (mon_q[c] !== exp_b[c]) begin bad++; $display("FAIL stall_beat[%0d] got=%h exp=%h", c, mon_q[c], exp_b[c]); end
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        vld_i = 4'b0100; last_i = 4'b0000; data_i[2] = 8'hD1;
        tick();
        data_i[2] = 8'hD2;
        @(negedge clk);
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL rstmid_busy_pre got=%b exp=1", busy_o); end
        #1 rstn = 1'b0;
        #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy_o); end
        total++; if (vld_o !== 1'b0 && busy_o !== 1'b0) begin bad++; $display("FAIL rstmid_vld_busy got=%b exp=0", vld_o); end
        vld_i = 4'b0000;
        #1;
        total++; if (vld_o !== 1'b0) begin bad++; $display("FAIL rstmid_vld got=%b exp=0", vld_o); end
        tick();
        rstn = 1'b1;
        mon_q.delete();
        vld_i = 4'b0101; last_i = 4'b0101; data_i[0] = 8'hE0; data_i[2] = 8'hE2;
        @(negedge clk);
        total++; if (grant_o !== 4'b0001) begin bad++; $display("FAIL rstmid_grant got=%b exp=0001", grant_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rstmid_busy_post got=%b exp=0", busy_o); end
        tick();
        drain();
        total++; if (mon_q.size() !== 1) begin bad++; $display("FAIL rstmid_beats got=%0d exp=1", mon_q.size()); end
        if (mon_q.size() >= 1) begin
            total++; if (mon_q[0] !== {1'b1, 8'hE0}) begin bad++; $display("FAIL rstmid_beat0 got=%h exp=1e0", mon_q[0]); end
        end
    endtask

    initial begin
        rstn   = 1'b0;
        vld_i  = 4'b0000;
        last_i = 4'b0000;
        rdy_i  = 1'b1;
        for (int i = 0; i < 4; i++) data_i[i] = 8'h00;
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_wrap();
        test_vld_drop();
        test_stall();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
